// File: rtl/common_pkg.sv
// common_pkg: operation codes, instruction word layout, opcode/funct constants
// and immediate range helper shared by the instruction encoder.
// Optional feature macro: INSTR_ENC_FPU_EN enables FADD_S/FSUB_S/FMUL_S/FDIV_S/FLW/FSW;
// without it those codes still exist here but are rejected by the encoder.
package common_pkg;

`ifdef INSTR_ENC_FPU_EN
    localparam logic FPU_EN = 1'b1;
`else
    localparam logic FPU_EN = 1'b0;
`endif

    typedef enum logic [5:0] {
        ENC_ADD    = 6'd0,  ENC_SUB   = 6'd1,  ENC_AND   = 6'd2,  ENC_OR    = 6'd3,
        ENC_XOR    = 6'd4,  ENC_SLL   = 6'd5,  ENC_SRL   = 6'd6,  ENC_SRA   = 6'd7,
        ENC_SLT    = 6'd8,  ENC_SLTU  = 6'd9,  ENC_ADDI  = 6'd10, ENC_ANDI  = 6'd11,
        ENC_ORI    = 6'd12, ENC_XORI  = 6'd13, ENC_SLTI  = 6'd14, ENC_SLTIU = 6'd15,
        ENC_SLLI   = 6'd16, ENC_SRLI  = 6'd17, ENC_SRAI  = 6'd18, ENC_LW    = 6'd19,
        ENC_SW     = 6'd20, ENC_BEQ   = 6'd21, ENC_BNE   = 6'd22, ENC_BLT   = 6'd23,
        ENC_BGE    = 6'd24, ENC_JAL   = 6'd25, ENC_JALR  = 6'd26, ENC_LUI   = 6'd27,
        ENC_AUIPC  = 6'd28, ENC_LI    = 6'd29, ENC_HALT  = 6'd30,
        ENC_FADD_S = 6'd32, ENC_FSUB_S = 6'd33, ENC_FMUL_S = 6'd34, ENC_FDIV_S = 6'd35,
        ENC_FLW    = 6'd36, ENC_FSW   = 6'd37
    } enc_op_t;

    typedef enum logic [3:0] {
        FMT_BAD, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_HALT
    } enc_fmt_t;

    typedef enum logic [1:0] {ST_IDLE, ST_FULL, ST_LI_LO, ST_DONE} enc_state_t;

    // R-type field view; other formats are packed into the same bit positions.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_FADD = 7'b0000000;
    localparam logic [6:0] F7_FSUB = 7'b0000100;
    localparam logic [6:0] F7_FMUL = 7'b0001000;
    localparam logic [6:0] F7_FDIV = 7'b0001100;

    // True when v is representable as an n-bit two's-complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int n);
        logic [31:0] s;
        s = $signed(v) >>> (n - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// instr_word_pack: combinational packer from operation + fields + immediate to a
// 32-bit instruction word, flagging illegal immediates and unsupported ops.
// Ports: op (enc_op_t code), rd/rs1/rs2 register indices, imm immediate,
//        word packed instruction, illegal request cannot be encoded.
// FP ops are accepted only when INSTR_ENC_FPU_EN is defined (see common_pkg).
module instr_word_pack
    import common_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    enc_fmt_t     fmt;
    logic [6:0]   opc;
    logic [6:0]   f7;
    logic [2:0]   f3;
    instruction_t w;

    always_comb begin
        fmt = FMT_BAD;
        opc = '0;
        f3  = '0;
        f7  = F7_BASE;
        case (enc_op_t'(op))
            ENC_ADD:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;  end
            ENC_SUB:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;  f7 = F7_ALT; end
            ENC_AND:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_AND;  end
            ENC_OR:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_OR;   end
            ENC_XOR:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_XOR;  end
            ENC_SLL:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLL;  end
            ENC_SRL:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;   end
            ENC_SRA:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;   f7 = F7_ALT; end
            ENC_SLT:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLT;  end
            ENC_SLTU:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLTU; end
            ENC_ADDI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_ADD;  end
            ENC_ANDI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_AND;  end
            ENC_ORI:    begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_OR;   end
            ENC_XORI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_XOR;  end
            ENC_SLTI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLT;  end
            ENC_SLTIU:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLTU; end
            ENC_SLLI:   begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SLL;  end
            ENC_SRLI:   begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;   end
            ENC_SRAI:   begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;   f7 = F7_ALT; end
            ENC_LW:     begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_W;    end
            ENC_SW:     begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_W;    end
            ENC_BEQ:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BEQ;  end
            ENC_BNE:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BNE;  end
            ENC_BLT:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLT;  end
            ENC_BGE:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGE;  end
            ENC_JAL:    begin fmt = FMT_J;  opc = OPC_JAL;    end
            ENC_JALR:   begin fmt = FMT_I;  opc = OPC_JALR;   f3 = F3_ADD;  end
            ENC_LUI:    begin fmt = FMT_U;  opc = OPC_LUI;    end
            ENC_AUIPC:  begin fmt = FMT_U;  opc = OPC_AUIPC;  end
            ENC_HALT:   fmt = FMT_HALT;
            // FP arithmetic keeps funct3 (rounding mode) at 000.
            ENC_FADD_S: begin fmt = FPU_EN ? FMT_R : FMT_BAD; opc = OPC_OP_FP; f7 = F7_FADD; end
            ENC_FSUB_S: begin fmt = FPU_EN ? FMT_R : FMT_BAD; opc = OPC_OP_FP; f7 = F7_FSUB; end
            ENC_FMUL_S: begin fmt = FPU_EN ? FMT_R : FMT_BAD; opc = OPC_OP_FP; f7 = F7_FMUL; end
            ENC_FDIV_S: begin fmt = FPU_EN ? FMT_R : FMT_BAD; opc = OPC_OP_FP; f7 = F7_FDIV; end
            ENC_FLW:    begin fmt = FPU_EN ? FMT_I : FMT_BAD; opc = OPC_LOAD_FP;  f3 = F3_W; end
            ENC_FSW:    begin fmt = FPU_EN ? FMT_S : FMT_BAD; opc = OPC_STORE_FP; f3 = F3_W; end
            default:    fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        w       = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R:    w = '{funct7: f7, rs2: rs2, rs1: rs1, funct3: f3, rd: rd, opcode: opc};
            FMT_I:    begin w = {imm[11:0], rs1, f3, rd, opc}; illegal = !fits_signed(imm, 12); end
            FMT_SH:   begin w = {f7, imm[4:0], rs1, f3, rd, opc}; illegal = |imm[31:5]; end
            FMT_S:    begin w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc}; illegal = !fits_signed(imm, 12); end
            FMT_B:    begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                illegal = !fits_signed(imm, 13) || imm[0];
            end
            FMT_J:    begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                illegal = !fits_signed(imm, 21) || imm[0];
            end
            FMT_U:    w = {imm[31:12], rd, opc};
            FMT_HALT: w = '1;
            default:  illegal = 1'b1;
        endcase
    end

    assign word = w;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I(+F) encoder, symbolic requests in, packed words out.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_op/req_rd/req_rs1/
//        req_rs2/req_imm request handshake; instr_valid/instr_ready/instr output
//        handshake; instr_count words emitted; err one-cycle reject pulse.
// Optional FP ops enabled by INSTR_ENC_FPU_EN (see common_pkg).
module instr_encoder
    import common_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [15:0] instr_count,
    output logic        err
);
    enc_state_t   state, state_n;
    instruction_t lo_word;
    logic [31:0]  word, p_imm;
    logic [5:0]   p_op;
    logic [4:0]   p_rs1;
    logic         illegal, cur_hi, cur_halt;
    logic         li, li_fit, li_two, accept, consume, load;

    // LI maps onto ADDI when it fits, otherwise onto LUI of the rounded upper part
    // (imm + 0x800 carries imm[11] into imm[31:12]) followed by an ADDI low word.
    assign li     = req_op == ENC_LI;
    assign li_fit = fits_signed(req_imm, 12);
    assign li_two = li && !li_fit;
    assign p_op   = li ? (li_fit ? ENC_ADDI : ENC_LUI) : req_op;
    assign p_rs1  = li ? 5'd0 : req_rs1;
    assign p_imm  = li_two ? req_imm + 32'h800 : req_imm;

    instr_word_pack u_pack (
        .op      (p_op),
        .rd      (req_rd),
        .rs1     (p_rs1),
        .rs2     (req_rs2),
        .imm     (p_imm),
        .word    (word),
        .illegal (illegal)
    );

    // LI_LO presents the low word straight after the high word is taken.
    assign instr_valid = state == ST_FULL || state == ST_LI_LO;
    assign req_ready   = state == ST_IDLE || (state == ST_FULL && instr_ready && !cur_hi && !cur_halt);
    assign accept      = req_valid && req_ready;
    assign consume     = instr_valid && instr_ready;
    assign load        = accept && !illegal;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  state_n = load ? ST_FULL : ST_IDLE;
            ST_FULL:  state_n = !consume ? ST_FULL : cur_hi ? ST_LI_LO : cur_halt ? ST_DONE
                              : load ? ST_FULL : ST_IDLE;
            ST_LI_LO: state_n = consume ? ST_IDLE : ST_FULL;
            default:  state_n = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            instr       <= '0;
            lo_word     <= '0;
            cur_hi      <= 1'b0;
            cur_halt    <= 1'b0;
            instr_count <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            err         <= accept && illegal;
            instr_count <= instr_count + 16'(consume);
            if (load) begin
                instr    <= word;
                lo_word  <= '{funct7: req_imm[11:5], rs2: req_imm[4:0], rs1: req_rd,
                              funct3: F3_ADD, rd: req_rd, opcode: OPC_OP_IMM};
                cur_hi   <= li_two && |req_imm[11:0];
                cur_halt <= req_op == ENC_HALT;
            end else if (state == ST_FULL && consume && cur_hi) begin
                instr  <= lo_word;
                cur_hi <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder; expected words are queued
// as requests are driven and compared by a monitor as the DUT hands them over.
module tb_instr_encoder;
    import common_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [15:0] instr_count;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [31:0] mon_exp;
    logic [15:0] exp_count = '0;

    instr_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_count (instr_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h expected none", instr);
            end else begin
                mon_exp = q.pop_front();
                if (instr !== mon_exp) begin
                    errors++;
                    $display("FAIL word: got %h expected %h", instr, mon_exp);
                end
            end
        end
    end

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        exp_count++;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, output int waits);
        waits = 0;
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 for op %0d", op);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d words pending expected 0", name, q.size());
        end
        checks++;
        if (instr_count !== exp_count) begin
            errors++;
            $display("FAIL %s_count: got %0d expected %0d", name, instr_count, exp_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({instr_valid, instr, instr_count, err} !== 50'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b i=%h c=%0d e=%b expected all 0",
                     instr_valid, instr, instr_count, err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_count = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_latency();
        int w;
        push(32'h002081B3);
        send(ENC_ADD, 5'd3, 5'd1, 5'd2, 32'd0, w);
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency: got instr_valid=%b expected 1", instr_valid);
        end
        drain("add");
    endtask

    task automatic test_encodings();
        logic [5:0]  ops [14] = '{ENC_ADD, ENC_SUB, ENC_AND, ENC_BEQ, ENC_BNE, ENC_SW, ENC_LW,
                                  ENC_SLLI, ENC_SRAI, ENC_JAL, ENC_ADDI, ENC_LI, ENC_LI, ENC_AUIPC};
        logic [4:0]  rds [14] = '{5'd3, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 5'd5,
                                  5'd1, 5'd1, 5'd1, 5'd1, 5'd7, 5'd6, 5'd2};
        logic [4:0]  r1s [14] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1,
                                  5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [4:0]  r2s [14] = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd0,
                                  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [31:0] ims [14] = '{32'd0, 32'd0, 32'd0, 32'd8, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'd16,
                                  32'd31, 32'd3, 32'd2048, 32'hFFFFF800, 32'hFFFFFFFB,
                                  32'h12345000, 32'h00001ABC};
        logic [31:0] exp [14] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h00208463,
                                  32'hFE209EE3, 32'hFE20AE23, 32'h0100A283, 32'h01F11093,
                                  32'h40315093, 32'h001000EF, 32'h80000093, 32'hFFB00393,
                                  32'h12345337, 32'h00001117};
        int w;
        for (int i = 0; i < 14; i++) begin
            push(exp[i]);
            send(ops[i], rds[i], r1s[i], r2s[i], ims[i], w);
        end
        drain("encodings");
    endtask

    task automatic test_li();
        int w;
        push(32'h123462B7);
        push(32'hFFF28293);
        send(ENC_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF, w);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, req_ready} !== 2'b10) begin
                errors++;
                $display("FAIL li_word%0d: got valid=%b ready=%b expected valid=1 ready=0",
                         i, instr_valid, req_ready);
            end
        end
        drain("li_split");
        push(32'h000010B7);
        push(32'h80008093);
        send(ENC_LI, 5'd1, 5'd0, 5'd0, 32'h00000800, w);
        drain("li_round");
    endtask

    task automatic test_illegal();
        logic [5:0]  ops [9] = '{ENC_ADDI, ENC_BEQ, ENC_BLT, ENC_SLLI, ENC_JAL, ENC_JAL,
                                 ENC_LW, 6'd31, 6'd63};
        logic [31:0] ims [9] = '{32'd2048, 32'd7, 32'd4096, 32'd32, 32'd3, 32'h00100000,
                                 32'hFFFFF7FF, 32'd0, 32'd0};
        int w;
        for (int i = 0; i < 9; i++) begin
            send(ops[i], 5'd1, 5'd0, 5'd2, ims[i], w);
            @(negedge clk);
            checks++;
            if ({err, instr_valid} !== 2'b10) begin
                errors++;
                $display("FAIL illegal%0d_pulse: got err=%b valid=%b expected err=1 valid=0",
                         i, err, instr_valid);
            end
            @(negedge clk);
            checks++;
            if ({err, instr_valid} !== 2'b00) begin
                errors++;
                $display("FAIL illegal%0d_after: got err=%b valid=%b expected 0 0",
                         i, err, instr_valid);
            end
            @(posedge clk); #1;
        end
        drain("illegal");
    endtask

    task automatic test_fpu();
        logic [5:0]  ops [2] = '{ENC_FADD_S, ENC_FLW};
        logic [4:0]  r2s [2] = '{5'd3, 5'd0};
        logic [31:0] ims [2] = '{32'd0, 32'd8};
        logic [31:0] exp [2] = '{32'h003100D3, 32'h00812087};
        logic        exp_err = !FPU_EN;
        int w;
        for (int i = 0; i < 2; i++) begin
            if (FPU_EN) push(exp[i]);
            send(ops[i], 5'd1, 5'd2, r2s[i], ims[i], w);
            @(negedge clk);
            checks++;
            if (err !== exp_err) begin
                errors++;
                $display("FAIL fpu%0d_err: got %b expected %b", i, err, exp_err);
            end
            @(posedge clk); #1;
        end
        drain("fpu");
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops [4] = '{ENC_ADD, ENC_XORI, ENC_SLT, ENC_JALR};
        logic [31:0] exp [4] = '{32'h002081B3, 32'h0050C193, 32'h0020A1B3, 32'h000081E7};
        logic [31:0] ims [4] = '{32'd0, 32'd5, 32'd0, 32'd0};
        int w;
        for (int i = 0; i < 4; i++) push(exp[i]);
        for (int i = 0; i < 4; i++) begin
            send(ops[i], 5'd3, 5'd1, 5'd2, ims[i], w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL b2b%0d_wait: got %0d stall cycles expected 0", i, w);
            end
        end
        drain("b2b");
    endtask

    task automatic test_backpressure();
        int w;
        instr_ready = 1'b0;
        push(32'h002081B3);
        send(ENC_ADD, 5'd3, 5'd1, 5'd2, 32'd0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, req_ready, instr} !== {2'b10, 32'h002081B3}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b r=%b i=%h expected v=1 r=0 i=002081b3",
                         i, instr_valid, req_ready, instr);
            end
        end
        @(posedge clk); #1;
        instr_ready = 1'b1;
        drain("backpressure");
    endtask

    task automatic test_reset_mid_li();
        int w;
        push(32'h123462B7);
        send(ENC_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF, w);
        @(posedge clk); #1;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL midli_lo_pending: got valid=%b expected 1", instr_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_valid, instr, instr_count, err} !== 50'd0) begin
            errors++;
            $display("FAIL midli_reset: got v=%b i=%h c=%0d e=%b expected all 0",
                     instr_valid, instr, instr_count, err);
        end
        exp_count = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL midli_no_low%0d: got valid=%b expected 0", i, instr_valid);
            end
        end
        @(posedge clk); #1;
        drain("midli");
    endtask

    task automatic test_halt();
        int w;
        push(32'hFFFFFFFF);
        send(ENC_HALT, 5'd0, 5'd0, 5'd0, 32'd0, w);
        drain("halt");
        req_op = ENC_ADD;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, instr_valid} !== 2'b00) begin
                errors++;
                $display("FAIL done%0d: got ready=%b valid=%b expected 0 0",
                         i, req_ready, instr_valid);
            end
        end
        req_valid = 1'b0;
        drain("done");
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_encodings();
        test_li();
        test_illegal();
        test_fpu();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_li();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I(+F) instruction encoder: the inverse of the core's instruction decoder. Accepts symbolic operation requests (op, rd, rs1, rs2, imm) over a valid/ready handshake and emits packed 32-bit instruction words over a second valid/ready handshake. It expands the `LI` pseudo-op into `LUI`+`ADDI` when needed and range-checks immediates. It sits between the test/boot sequencer and instruction memory write port, and feeds on-chip program generation and self-test.

## Interface
- Parameters: none.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_op` in 6: `enc_op_t` operation.
- `req_rd` in 5: destination register index.
- `req_rs1` in 5: source 1 register index.
- `req_rs2` in 5: source 2 register index.
- `req_imm` in 32: signed immediate or byte offset.
- `instr_valid` out 1: `instr` holds a word.
- `instr_ready` in 1: downstream consumes the word when `instr_valid && instr_ready`.
- `instr` out 32: encoded instruction word.
- `instr_count` out 16: words emitted since reset; wraps 0xFFFF→0.
- `err` out 1: one-cycle pulse on a rejected request.

## Operation
- Base ops: `ADD SUB AND OR XOR SLL SRL SRA SLT SLTU ADDI ANDI ORI XORI SLTI SLTIU SLLI SRLI SRAI LW SW BEQ BNE BLT BGE JAL JALR LUI AUIPC LI HALT`.
- Field layout per `encoding_t` block assignment. Opcode, funct3 and funct7 values match the `normal_instructions_t` patterns.
- Immediate legality:
  - I/S: signed 12-bit.
  - B: signed 13-bit, even.
  - J: signed 21-bit, even.
  - Shifts: 0–31.
  - LUI/AUIPC: `imm[31:12]` used, low bits ignored.
  - Illegal immediate or unsupported op: request consumed, `err` pulses next cycle, nothing emitted, count unchanged.
- `LI rd, imm`:
  - Signed 12-bit fit → `ADDI rd,x0,imm`.
  - Otherwise → `LUI rd,(imm[31:12]+imm[11])`, then `ADDI rd,rd,imm[11:0]`.
  - The `ADDI` is omitted when `imm[11:0]==0`.
- `HALT` emits 0xFFFFFFFF, then the block enters DONE.
- FSM states:
  - IDLE: output empty.
  - FULL: word held.
  - LI_LO: second LI word pending.
  - DONE.
- Transitions:
  - IDLE→FULL on accept.
  - FULL→IDLE on consume with no new accept.
  - FULL→FULL on simultaneous consume+accept.
  - FULL→LI_LO on consume of a two-word LI's first word.
  - LI_LO→FULL next cycle.
  - FULL(HALT)→DONE on consume.
- `req_ready` = (IDLE) or (FULL and `instr_ready` and current word is not LI-high and not HALT). It is low in LI_LO and DONE.
- DONE exits only by reset.
- Reset (also mid-operation): state IDLE, `instr_valid`=0, `instr`=0, `instr_count`=0, `err`=0. The pending LI low word is discarded.

## Timing
- Accept in cycle N → `instr_valid` in N+1 (registered output, no combinational path req→instr).
- Throughput is one word/cycle with `instr_ready` held high.
- Two-word LI: words at N+1 and N+2 under no backpressure. No new request is accepted until the LI low word is loaded.
- `instr`/`instr_valid` hold stable while `instr_valid && !instr_ready`.
- `instr_count` increments in the cycle after each consume.
- `err` is registered: high exactly one cycle, at N+1.

## Configuration
- `INSTR_ENC_FPU_EN` defined: adds `FADD_S FSUB_S FMUL_S FDIV_S FLW FSW`.
  - Register indices are f-registers.
  - Rounding-mode field (funct3) is 000 for arithmetic ops.
  - FLW/FSW use I/S immediate rules.
- Undefined: those `enc_op_t` codes are still defined in the package but are rejected with `err`.

## Structure
- `common_pkg` gains:
  - `enc_op_t` (6-bit enum, fixed codes, FPU codes included).
  - `localparam` opcode/funct constants derived from `normal_instructions_t`.
- Reuse `instruction_t` for word assembly.
- One sub-module, `instr_word_pack`: combinational op+fields+imm → {word, illegal}. The `instr_encoder` top holds FSM, output register, LI split and counter.

## Test plan
- `ADD x3,x1,x2` → `instr`=0x002081B3 one cycle after accept; `instr_count`=1.
- `LI x5,0x12345FFF` → 0x123462B7 then 0xFFF28293 on consecutive cycles; `req_ready` low in between.
- `BEQ x1,x2,+8` → 0x00208463; `BEQ` with imm=7 → `err` pulse, no word.
- `ADDI x1,x0,2048` → `err` one cycle, `instr_valid` stays 0, count unchanged.
- Backpressure: `instr_ready` low 3 cycles after `ADD` → `instr` stable and `req_ready`=0 throughout; one word delivered on release.
- `HALT` → 0xFFFFFFFF, then `req_ready`=0 permanently.
- `rst_n` pulse mid-LI → outputs zero and the low word is never emitted.
- `FADD_S f1,f2,f3` → 0x003100D3 with `INSTR_ENC_FPU_EN`; `err` without it.
